// File: rtl/mem_arb_pkg.sv
// Shared constants for the data-RAM port arbiter: requester count, requester
// indices and the default burst cap.
package mem_arb_pkg;

  localparam int unsigned N_REQ     = 3;
  localparam int unsigned REQ_DATA  = 0;
  localparam int unsigned REQ_FETCH = 1;
  localparam int unsigned REQ_DMA   = 2;
  localparam int unsigned BURST_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: one-hot grant to the first asserted request found
// scanning ptr, ptr+1, ... modulo N. Purely combinational.
module rr_pick #(
  parameter  int unsigned N     = 3,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = (ptr > PTR_W'(N - 1)) ? '0 : ptr;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered-read data RAM between the CPU
// data port, instruction fetch and the UART RX DMA, with bounded locked bursts.
module mem_port_arbiter #(
  parameter int unsigned N_REQ     = mem_arb_pkg::N_REQ,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = mem_arb_pkg::BURST_MAX
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic             locked;
  logic [CNT_W-1:0] beat_cnt;
  logic [N_REQ-1:0] rd_pend;

  logic [N_REQ-1:0] rr_gnt;
  logic             hold;
  logic             any_gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_we;
  logic             gnt_lock;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .gnt (rr_gnt)
  );

  // Locked owner keeps the port until its burst reaches the cap.
  always_comb begin
    hold = locked && req[owner] && lock[owner] && (beat_cnt < CNT_W'(BURST_MAX));
    gnt  = hold ? (N_REQ'(1) << owner) : rr_gnt;
  end

  // Steer the granted requester onto the memory port.
  always_comb begin
    any_gnt   = |gnt;
    gnt_idx   = '0;
    gnt_we    = 1'b0;
    gnt_lock  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx   = PTR_W'(i);
        gnt_we    = we[i];
        gnt_lock  = lock[i];
        mem_addr  = addr[i*ADDR_W +: ADDR_W];
        mem_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
    mem_en = any_gnt;
    mem_we = any_gnt & gnt_we;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      ptr      <= '0;
      owner    <= '0;
      locked   <= 1'b0;
      beat_cnt <= '0;
      rd_pend  <= '0;
    end else begin
      rd_pend <= gnt & ~we;
      if (any_gnt) begin
        ptr    <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        owner  <= gnt_idx;
        locked <= gnt_lock;
        // Count saturates at the cap so a lone owner re-winning by round-robin stays unlocked-equivalent.
        if ((gnt_idx == owner) && locked)
          beat_cnt <= (beat_cnt == CNT_W'(BURST_MAX)) ? beat_cnt : beat_cnt + 1'b1;
        else
          beat_cnt <= CNT_W'(1);
      end else begin
        locked   <= 1'b0;
        beat_cnt <= '0;
      end
    end
  end

  assign rvalid = rd_pend;
  assign rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a behavioural arbitration and memory model.
module tb_mem_port_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BM = 8;
  localparam int unsigned MW = 64;

  logic            sysclk;
  logic            reset;
  logic [N-1:0]    req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            preload;

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .sysclk(sysclk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic logic [DW-1:0] pat(input int unsigned i);
    return 32'hA500_0000 | (DW'(i) * 32'h0001_0101);
  endfunction

  // Registered-read RAM fixture driven by the DUT memory port.
  logic [DW-1:0] ram [MW];
  always @(posedge sysclk) begin
    if (preload) begin
      for (int unsigned i = 0; i < MW; i++) ram[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  // Behavioural model state
  int            m_ptr, m_owner, m_beats;
  bit            m_locked;
  logic [N-1:0]  m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] mmem [MW];

  // Stimulus and observations
  bit            d_reset;
  logic [N-1:0]  d_req, d_lock, d_we;
  logic [AW-1:0] d_addr [N];
  logic [DW-1:0] d_wdata [N];
  logic [N-1:0]  o_gnt, o_rvalid;
  logic [DW-1:0] o_rdata;
  logic          o_mem_en, o_mem_we;

  int n_tests, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    d_reset = 1'b0;
    d_req = '0; d_lock = '0; d_we = '0;
    for (int i = 0; i < int'(N); i++) begin
      d_addr[i] = '0; d_wdata[i] = '0;
    end
  endtask

  // One cycle: drive, compare against the model, then advance the model.
  task automatic step();
    int k;
    int c;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] next_rv;
    int idx;
    @(negedge sysclk);
    reset = d_reset; req = d_req; lock = d_lock; we = d_we;
    for (int i = 0; i < int'(N); i++) begin
      addr[i*AW +: AW]  = d_addr[i];
      wdata[i*DW +: DW] = d_wdata[i];
    end
    #1;
    k = -1;
    if (m_locked && d_req[m_owner] && d_lock[m_owner] && m_beats < int'(BM)) k = m_owner;
    else begin
      for (int j = 0; j < int'(N); j++) begin
        c = (m_ptr + j) % int'(N);
        if (k < 0 && d_req[c]) k = c;
      end
    end
    exp_gnt = '0;
    if (k >= 0) exp_gnt[k] = 1'b1;

    check("rvalid", 64'(rvalid), 64'(m_rvalid));
    if (m_rvalid != '0) check("rdata", 64'(rdata), 64'(m_rdata));
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("mem_en", 64'(mem_en), 64'(k >= 0));
    if (k >= 0) begin
      check("mem_we", 64'(mem_we), 64'(d_we[k]));
      check("mem_addr", 64'(mem_addr), 64'(d_addr[k]));
      if (d_we[k]) check("mem_wdata", 64'(mem_wdata), 64'(d_wdata[k]));
    end else begin
      check("mem_we_idle", 64'(mem_we), 64'(0));
    end
    o_gnt = gnt; o_rvalid = rvalid; o_rdata = rdata; o_mem_en = mem_en; o_mem_we = mem_we;

    next_rv = '0;
    if (k >= 0) begin
      idx = int'(d_addr[k][7:2]);
      if (d_we[k]) mmem[idx] = d_wdata[k];
      else begin
        next_rv[k] = 1'b1;
        m_rdata = mmem[idx];
      end
      if (k == m_owner && m_locked) m_beats = (m_beats + 1 > int'(BM)) ? int'(BM) : m_beats + 1;
      else m_beats = 1;
      m_locked = d_lock[k];
      m_owner  = k;
      m_ptr    = (k + 1) % int'(N);
    end else begin
      m_locked = 1'b0;
      m_beats  = 0;
    end
    if (d_reset) begin
      m_ptr = 0; m_owner = 0; m_locked = 1'b0; m_beats = 0;
      next_rv = '0;
    end
    m_rvalid = next_rv;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    preload = 1'b1;
    reset = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    for (int unsigned i = 0; i < MW; i++) mmem[i] = pat(i);
    m_ptr = 0; m_owner = 0; m_locked = 1'b0; m_beats = 0; m_rvalid = '0; m_rdata = '0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    preload = 1'b0;

    // Reset state
    idle_inputs(); d_reset = 1'b1;
    step();
    idle_inputs();
    step();
    check("reset_rvalid", 64'(o_rvalid), 64'(0));
    check("reset_mem_en", 64'(o_mem_en), 64'(0));

    // All three read: grants rotate 0,1,2,0 and data returns a cycle later
    d_req = 3'b111; d_we = '0;
    d_addr[0] = 32'h04; d_addr[1] = 32'h08; d_addr[2] = 32'h0C;
    step(); check("rr_g0", 64'(o_gnt), 64'(3'b001));
    step(); check("rr_g1", 64'(o_gnt), 64'(3'b010));
    check("rr_rv0", 64'(o_rvalid), 64'(3'b001)); check("rr_rd0", 64'(o_rdata), 64'(32'hA501_0101));
    step(); check("rr_g2", 64'(o_gnt), 64'(3'b100));
    check("rr_rv1", 64'(o_rvalid), 64'(3'b010)); check("rr_rd1", 64'(o_rdata), 64'(32'hA502_0202));
    step(); check("rr_g3", 64'(o_gnt), 64'(3'b001));
    check("rr_rv2", 64'(o_rvalid), 64'(3'b100)); check("rr_rd2", 64'(o_rdata), 64'(32'hA503_0303));
    idle_inputs();
    step(); check("rr_rv3", 64'(o_rvalid), 64'(3'b001));

    // Locked DMA burst capped at BM, then requester 0, then DMA resumes
    d_req = 3'b100; d_lock = 3'b100; d_addr[2] = 32'h20;
    step(); check("burst_first", 64'(o_gnt), 64'(3'b100));
    d_req = 3'b101;
    for (int b = 2; b <= int'(BM); b++) begin
      step(); check("burst_hold", 64'(o_gnt), 64'(3'b100));
    end
    step(); check("burst_cap_g0", 64'(o_gnt), 64'(3'b001));
    d_req = 3'b100;
    step(); check("burst_resume", 64'(o_gnt), 64'(3'b100));
    idle_inputs();
    step();

    // Write by fetch then read-back by data port
    d_req = 3'b010; d_we = 3'b010; d_addr[1] = 32'h10; d_wdata[1] = 32'hDEAD_BEEF;
    step(); check("wr_gnt", 64'(o_gnt), 64'(3'b010)); check("wr_we", 64'(o_mem_we), 64'(1));
    idle_inputs(); d_req = 3'b001; d_addr[0] = 32'h10;
    step(); check("rd_gnt", 64'(o_gnt), 64'(3'b001)); check("rd_we", 64'(o_mem_we), 64'(0));
    check("wr_no_rvalid", 64'(o_rvalid), 64'(0));
    idle_inputs();
    step(); check("rd_rvalid", 64'(o_rvalid), 64'(3'b001)); check("rd_data", 64'(o_rdata), 64'(32'hDEAD_BEEF));

    // Idle gap after a grant to 1; ptr stays at 2
    d_req = 3'b010;
    step(); check("idle_pre", 64'(o_gnt), 64'(3'b010));
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      step(); check("idle_mem_en", 64'(o_mem_en), 64'(0));
    end
    d_req = 3'b101;
    step(); check("idle_ptr2", 64'(o_gnt), 64'(3'b100));

    // Reset the cycle after a read grant drops the response
    d_req = 3'b001; d_addr[0] = 32'h04;
    step(); check("rst_rd_gnt", 64'(o_gnt), 64'(3'b001));
    idle_inputs(); d_reset = 1'b1;
    step();
    idle_inputs();
    step(); check("rst_drop", 64'(o_rvalid), 64'(0));
    d_req = 3'b011;
    step(); check("rst_ptr0", 64'(o_gnt), 64'(3'b001));
    idle_inputs();
    repeat (3) step();

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      d_reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < int'(N); i++) begin
        d_req[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) d_lock[i] = ~d_lock[i];
        d_we[i]  = $urandom_range(0, 1) == 1;
        d_addr[i] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        d_wdata[i] = $urandom;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one single-port, registered-read data RAM between three requesters:
- CPU load/store port
- instruction-fetch port
- UART receive DMA engine

It sits between the requesters and the DataMem array on the `sysclk` domain. It issues at most one memory access per cycle. Each requester can hold the port for a bounded burst.

## Interface
Parameters:
- `N_REQ`, 3, number of requesters; index 0 = data, 1 = fetch, 2 = DMA
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word width
- `BURST_MAX`, 8, maximum consecutive grants to one locked owner (≥1)

Ports:
- `sysclk`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `req`  in  N_REQ  access request per requester; held until granted
- `lock`  in  N_REQ  requester asks to keep the port after this grant (burst)
- `we`  in  N_REQ  1 = write, 0 = read
- `addr`  in  N_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
- `wdata`  in  N_REQ*DATA_W  packed write data
- `gnt`  out  N_REQ  one-hot or zero; same-cycle grant
- `rvalid`  out  N_REQ  read data valid for requester k, one cycle after its read grant
- `rdata`  out  DATA_W  shared read-data return, qualified by `rvalid`
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  memory write strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after a read `mem_en`

## Operation
State:
- `ptr` (priority pointer, 0..N_REQ-1)
- `owner` (last grantee)
- `locked` flag
- `beat_cnt` (0..BURST_MAX)
- `rd_pend` (N_REQ, one-hot)

Arbitration (combinational, every cycle):
- If `locked`, `req[owner]` and `lock[owner]` are all high and `beat_cnt < BURST_MAX`: grant `owner`.
- Otherwise: grant the first asserted `req` scanning `ptr`, `ptr+1`, … modulo N_REQ.
- No `req` asserted: `gnt=0`, `mem_en=0`, `mem_we=0`; `mem_addr`/`mem_wdata` are don't-care.

Memory drive:
- `mem_en=|gnt`.
- `mem_we=we[k]`, `mem_addr`/`mem_wdata` from granted k.

Registered updates on grant to k:
- `ptr <= (k+1) mod N_REQ`; `owner <= k`.
- `locked <= lock[k]`.
- `beat_cnt <= (k==owner && locked) ? beat_cnt+1 : 1`.

When no grant occurs:
- `locked <= 0`, `beat_cnt <= 0`.
- `ptr` and `owner` are unchanged.

Burst rules:
- A burst is capped at BURST_MAX grants.
- On reaching the cap, the owner competes under normal round-robin with `ptr=owner+1`, so other requesters win first.
- `lock` on a requester not currently being granted has no effect.

Read return:
- `rd_pend <= gnt & ~we` (bitwise over requesters).
- `rvalid = rd_pend`; `rdata = mem_rdata`.
- Writes produce no response.

Reset values:
- `ptr=0`, `owner=0`, `locked=0`, `beat_cnt=0`, `rd_pend=0`.
- Therefore `rvalid=0`.
- `gnt`/`mem_*` follow combinationally from the reset state (requester 0 has highest priority).

Reset mid-operation: any pending read response is dropped. The requester must reissue.

## Timing
- Grant latency: 0 cycles. `gnt[k]` is valid in the same cycle as `req[k]` if k wins.
- The requester may change `addr`/`wdata`/`req` on the cycle after `gnt`.
- Read latency: exactly 1 cycle from grant to `rvalid`.
- Throughput: one access per cycle. Back-to-back reads to different requesters return in grant order on consecutive cycles.
- Fairness: unlocked, an asserted request is granted within N_REQ-1 other grants. Locked worst case is (N_REQ-1)*BURST_MAX cycles.
- Simultaneous read response for grant i and new grant j in the same cycle is legal; `rvalid` and `gnt` are independent.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `N_REQ`
  - index constants `REQ_DATA=0`, `REQ_FETCH=1`, `REQ_DMA=2`
  - `BURST_MAX` default
- Sub-module `rr_pick`: rotating-priority encoder. Inputs are `req` vector and `ptr`; output is a one-hot grant. Purely combinational; reusable by the peripheral-bus arbiter.

## Test plan
- Reset, then `req=3'b111`, all reads:
  - grants go 0, 1, 2, 0 on consecutive cycles;
  - `rvalid` goes 3'b001, 3'b010, 3'b100 one cycle later each;
  - `rdata` matches preloaded words.
- `req[2]` with `lock[2]=1` held, `req[0]` asserted, BURST_MAX=8:
  - DMA gets 8 consecutive grants;
  - requester 0 is granted on cycle 9;
  - DMA resumes after it.
- Write of 0xDEADBEEF to 0x10 by requester 1, then read of 0x10 by requester 0 on the next cycle:
  - `mem_we` is high for one cycle;
  - `rvalid[0]` is high with `rdata=0xDEADBEEF`;
  - `rvalid[1]` never asserts.
- `req=0` for 5 cycles after a grant to 1:
  - `mem_en=0`, `ptr` stays 2, `locked` clears;
  - next `req=3'b101` grants requester 2 first.
- `reset` asserted the cycle after a read grant:
  - `rvalid=0` next cycle;
  - `ptr=0`;
  - no stale response appears afterward.
